// File: rtl/milano_pkg.sv
// Shared types and helpers for the data-memory responder slice.
package milano_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } dmem_state_e;

  // Wide enough for GNT_WAIT values 0..15.
  localparam int GNT_CNT_W = 4;

  // True when a byte address falls inside [base, base + 4*depth).
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned depth);
    logic [32:0] off;
    logic [32:0] span;
    off  = {1'b0, addr} - {1'b0, base};
    span = 33'(depth) << 2;
    return off < span;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side req/gnt/rvalid data bus, seen from the initiator (master) and responder (slave).
interface dmem_responder_if;

  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );

endinterface

// File: rtl/dmem_sram.sv
// Single-port RAM with synchronous read and per-byte write enables; contents are never reset.
module dmem_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core data bus: optional grant stall, one-cycle response, byte-write RAM.
module dmem_responder
  import milano_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned GNT_WAIT    = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e          state_q, state_d;
  logic [GNT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 rvalid_q, rvalid_d;
  logic                 err_q, err_d;
  logic                 rd_q, rd_d;
  logic                 gnt;
  logic                 in_range;
  logic [31:0]          offset;
  logic [AW-1:0]        word_idx;
  logic [31:0]          ram_rdata;
  logic                 unused_offset_bits;

  assign in_range           = addr_in_window(bus.data_addr, BASE_ADDR, DEPTH_WORDS);
  assign offset             = bus.data_addr - BASE_ADDR;
  assign word_idx           = offset[AW+1:2];
  assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

  // Grant FSM; a dropped req while stalling is abandoned without an access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.data_req) begin
          if (GNT_WAIT == 0) begin
            gnt = 1'b1;
          end else begin
            cnt_d   = GNT_CNT_W'(GNT_WAIT - 1);
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (!bus.data_req) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          gnt     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - GNT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    gnt = gnt & rst_ni;
  end

  always_comb begin
    rvalid_d = gnt;
    err_d    = gnt & ~in_range;
    rd_d     = gnt & ~bus.data_we;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  // Out-of-range accesses never enable the RAM, so writes there are dropped.
  dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk_i   (clk_i),
    .en_i    (gnt & in_range),
    .we_i    (bus.data_we),
    .addr_i  (word_idx),
    .be_i    (bus.data_be),
    .wdata_i (bus.data_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.data_gnt    = gnt;
  assign bus.data_rvalid = rvalid_q;
  assign bus.data_err    = err_q;
  assign bus.data_rdata  = (rvalid_q && rd_q && !err_q) ? ram_rdata : 32'h0;

endmodule
